fetch_unit: RTL and testbench
=============================

# fetch_unit

LEGv8 instruction fetch stage, directly upstream of the instruction decoder. It holds the 64-bit program counter and requests 32-bit instruction words from instruction memory over a request/acknowledge handshake. Each fetched word is registered and presented to the decoder with a valid/ready handshake. Taken branches arrive as the branch PC plus the decoder's sign-extended word offset; the block redirects the PC and squashes any wrong-path fetch.

## Interface
- RESET_PC, 64'h0, PC loaded on reset; must be 4-byte aligned.
- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held high with stable imem_addr until the ack cycle.
- imem_addr  out  64  byte address of requested word; always equals internal PC.
- imem_ack  in  1  memory response; sampled only while imem_req=1.
- imem_rdata  in  32  instruction word, valid in the imem_ack cycle.
- instruction  out  32  registered instruction word to the decoder.
- instr_pc  out  64  address of `instruction`.
- instr_valid  out  1  `instruction` is valid. Equals held-valid AND NOT br_taken.
- dec_ready  in  1  decoder accepts; a transfer occurs when instr_valid & dec_ready.
- br_taken  in  1  redirect request, single-cycle pulse.
- br_pc  in  64  PC of the taken branch.
- br_imm  in  32  signed word offset, the decoder's immediate.

## Operation
- Branch target = br_pc + (sign-extend64(br_imm) << 2), modulo 2^64. Computed combinationally and loaded into PC on the br_taken edge.
- Sequential next PC = PC + 4, modulo 2^64; wraps from 64'hFFFF_FFFF_FFFF_FFFC to 0.
- States:
  - IDLE: reset state. The next cycle always goes to BUSY.
  - BUSY: imem_req=1.
    - imem_ack with squash=0: capture imem_rdata into `instruction` and PC into instr_pc, then go to HOLD.
    - imem_ack with squash=1: discard the word, clear squash, stay in BUSY (new PC already loaded).
  - HOLD: held-valid=1, imem_req=0.
    - On transfer: PC <= PC+4, held-valid clears, go to BUSY.
    - Without transfer: stay in HOLD; instruction and instr_pc stay stable.
- Redirect (br_taken=1), which has priority over everything except reset:
  - IDLE: PC <= target, go to BUSY.
  - BUSY, no ack this cycle:
    - PC <= target and squash <= 1, which keeps the outstanding ack's word from being used.
    - The outstanding request is retired at its ack with the old address, since memory latched it.
    - The new address is presented from the next cycle.
  - BUSY, ack this cycle: the word is discarded, PC <= target, squash stays 0, stay in BUSY.
  - HOLD:
    - instr_valid is forced low this cycle, so no transfer occurs.
    - Held-valid clears, PC <= target, go to BUSY.
- imem_addr changes while imem_req=1 only on a redirect. Memory treats the ack as answering the request it latched.
- Reset in any state, including mid-request:
  - State goes to IDLE, PC to RESET_PC, squash to 0, held-valid to 0, instruction and instr_pc to 0.
  - A later ack from an aborted request is ignored, because imem_req=0 in IDLE.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instruction=0, instr_pc=0, instr_valid=0.
- First imem_req=1 in the 2nd cycle after reset deasserts (IDLE lasts one cycle).
- Zero-wait memory (ack in the request cycle): instr_valid rises 1 cycle after the ack cycle.
- Peak throughput is 1 instruction per 2 cycles: BUSY 1 cycle, then HOLD at least 1 cycle.
- N wait states add N cycles of BUSY.
- Redirect to target request:
  - From HOLD or IDLE: imem_addr = target in the next cycle.
  - From BUSY: imem_addr = target in the next cycle, with squash pending until the old ack arrives.
- br_taken held for multiple cycles: each cycle re-evaluates the target from the current br_pc/br_imm. The last value wins.
- dec_ready is ignored while instr_valid=0.

## Test plan
- Sequential fetch:
  - Stimulus: RESET_PC=0, zero-wait memory returning word = addr; dec_ready=1.
  - Required: instr_pc sequence 0,4,8,C.
  - Required: instr_valid high every other cycle.
  - Required: first valid 3 cycles after reset deasserts.
- Wait states and stall:
  - Stimulus: ack 3 cycles after req; dec_ready low for 4 cycles in HOLD.
  - Required: imem_req high for exactly 3 cycles per word.
  - Required: instruction/instr_pc stable through the stall.
  - Required: no new imem_req until the transfer.
- Redirect in HOLD:
  - Stimulus: instr_pc=0x100, br_taken with br_pc=0x100, br_imm=-4.
  - Required: instr_valid low in the br_taken cycle.
  - Required: next imem_addr=0xF0.
  - Required: the next delivered instr_pc=0xF0.
- Redirect during BUSY:
  - Stimulus: request at 0x20 with 2-cycle latency; br_taken (target 0x400) in the first BUSY cycle.
  - Required: the word from 0x20 is never presented.
  - Required: the next delivered instr_pc=0x400.
- Wrap and reset mid-request:
  - Wrap stimulus: PC=64'hFFFF_FFFF_FFFF_FFFC transfers. Required: the next imem_addr=0.
  - Reset stimulus: reset asserted while imem_req=1, with an ack arriving during IDLE.
  - Required: the ack is ignored.
  - Required: the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// LEGv8 instruction fetch stage: owns the PC, fetches words over a req/ack
// handshake and hands them to the decoder through a valid/ready register.
//
//   state | meaning
//   IDLE  | one cycle after reset, no request outstanding
//   BUSY  | imem_req high, waiting for imem_ack
//   HOLD  | word registered and offered to the decoder, no request
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [63:0] instr_pc,
  output logic        instr_valid,
  input  logic        dec_ready,
  input  logic        br_taken,
  input  logic [63:0] br_pc,
  input  logic [31:0] br_imm
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] pc;
  logic [63:0] pc_seq;
  logic [63:0] br_target;
  logic        squash;
  logic        held_valid;
  logic        req_q;
  logic        xfer;

  // Word offset is sign-extended and scaled to bytes; both adds wrap mod 2^64.
  assign br_target = br_pc + {{30{br_imm[31]}}, br_imm, 2'b00};
  assign pc_seq    = pc + 64'd4;

  assign imem_addr   = pc;
  assign imem_req    = req_q;
  assign instr_valid = held_valid & ~br_taken;
  assign xfer        = instr_valid & dec_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      squash      <= 1'b0;
      held_valid  <= 1'b0;
      req_q       <= 1'b0;
      instruction <= 32'h0;
      instr_pc    <= 64'h0;
    end else begin
      case (state)
        IDLE: begin
          if (br_taken) pc <= br_target;
          state <= BUSY;
          req_q <= 1'b1;
        end

        BUSY: begin
          if (br_taken) begin
            pc <= br_target;
            // Without an ack this cycle, memory still owes us the old word.
            squash <= ~imem_ack;
          end else if (imem_ack) begin
            if (squash) begin
              squash <= 1'b0;
            end else begin
              instruction <= imem_rdata;
              instr_pc    <= pc;
              held_valid  <= 1'b1;
              req_q       <= 1'b0;
              state       <= HOLD;
            end
          end
        end

        HOLD: begin
          if (br_taken) begin
            pc         <= br_target;
            held_valid <= 1'b0;
            req_q      <= 1'b1;
            state      <= BUSY;
          end else if (xfer) begin
            pc         <= pc_seq;
            held_valid <= 1'b0;
            req_q      <= 1'b1;
            state      <= BUSY;
          end
        end

        default: begin
          state      <= IDLE;
          held_valid <= 1'b0;
          squash     <= 1'b0;
          req_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table plus hand-written
// sequences for wait states, redirect during a request, PC wrap and reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic        dec_ready;
  logic        br_taken;
  logic [63:0] br_pc;
  logic [31:0] br_imm;

  int checks = 0;
  int errors = 0;

  // memory model state
  int          wait_n = 0;
  logic        outstanding = 1'b0;
  logic [63:0] laddr = 64'h0;
  int          cnt = 0;
  logic        force_ack = 1'b0;
  logic [31:0] force_data = 32'h0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .dec_ready(dec_ready),
    .br_taken(br_taken), .br_pc(br_pc), .br_imm(br_imm)
  );

  // Memory latches the address at the start of a request and answers after
  // wait_n further request cycles with word = latched address.
  task automatic bfm();
    if (reset || !imem_req) begin
      outstanding = 1'b0;
      imem_ack    = force_ack;
      imem_rdata  = force_data;
    end else begin
      if (!outstanding) begin
        outstanding = 1'b1;
        laddr       = imem_addr;
        cnt         = wait_n;
      end
      if (cnt == 0) begin
        imem_ack    = 1'b1;
        imem_rdata  = laddr[31:0];
        outstanding = 1'b0;
      end else begin
        cnt        = cnt - 1;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
      end
    end
  endtask

  task automatic step(input logic r, input logic rdy, input logic bt,
                      input logic [63:0] bpc, input logic [31:0] bimm);
    @(negedge clk);
    reset     = r;
    dec_ready = rdy;
    br_taken  = bt;
    br_pc     = bpc;
    br_imm    = bimm;
    bfm();
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        bt;
    logic [63:0] bpc;
    logic [31:0] bimm;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_valid;
    logic [63:0] e_ipc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[19];

  initial begin
    int n;
    logic [63:0] hold_pc;
    logic [31:0] hold_ins;
    logic        saw_bad;

    //          rst   rdy   bt    br_pc   br_imm        req   addr    valid ipc     instr
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 64'h0,   32'h0,        1'b0, 64'h0,   1'b0, 64'h0,   32'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 64'h0,   32'h0,        1'b0, 64'h0,   1'b0, 64'h0,   32'h0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 64'h0,   32'h0,        1'b1, 64'h0,   1'b0, 64'h0,   32'h0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 64'h0,   32'h0,        1'b0, 64'h0,   1'b1, 64'h0,   32'h0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 64'h0,   32'h0,        1'b1, 64'h4,   1'b0, 64'h0,   32'h0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 64'h0,   32'h0,        1'b0, 64'h4,   1'b1, 64'h4,   32'h4};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 64'h0,   32'h0,        1'b1, 64'h8,   1'b0, 64'h4,   32'h4};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 64'h0,   32'h0,        1'b0, 64'h8,   1'b1, 64'h8,   32'h8};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 64'h0,   32'h0,        1'b1, 64'hC,   1'b0, 64'h8,   32'h8};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 64'h0,   32'h0,        1'b0, 64'hC,   1'b1, 64'hC,   32'hC};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 64'h0,   32'h0,        1'b1, 64'h10,  1'b0, 64'hC,   32'hC};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 64'h0,   32'h0,        1'b0, 64'h10,  1'b1, 64'h10,  32'h10};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 64'h0,   32'h0,        1'b0, 64'h10,  1'b1, 64'h10,  32'h10};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 64'h80,  32'h20,       1'b0, 64'h10,  1'b0, 64'h10,  32'h10};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 64'h0,   32'h0,        1'b1, 64'h100, 1'b0, 64'h10,  32'h10};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 64'h100, 32'hFFFFFFFC, 1'b0, 64'h100, 1'b0, 64'h100, 32'h100};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 64'h0,   32'h0,        1'b1, 64'hF0,  1'b0, 64'h100, 32'h100};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 64'h0,   32'h0,        1'b0, 64'hF0,  1'b1, 64'hF0,  32'hF0};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 64'h0,   32'h0,        1'b1, 64'hF4,  1'b0, 64'hF0,  32'hF0};

    reset = 1'b1; dec_ready = 1'b0; br_taken = 1'b0; br_pc = 64'h0; br_imm = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    step(1'b1, 1'b0, 1'b0, 64'h0, 32'h0);

    wait_n = 0;
    for (int i = 0; i < 19; i++) begin
      step(vecs[i].rst, vecs[i].rdy, vecs[i].bt, vecs[i].bpc, vecs[i].bimm);
      check($sformatf("v%0d_req", i),   {63'h0, imem_req},    {63'h0, vecs[i].e_req});
      check($sformatf("v%0d_addr", i),  imem_addr,            vecs[i].e_addr);
      check($sformatf("v%0d_valid", i), {63'h0, instr_valid}, {63'h0, vecs[i].e_valid});
      check($sformatf("v%0d_ipc", i),   instr_pc,             vecs[i].e_ipc);
      check($sformatf("v%0d_instr", i), {32'h0, instruction}, {32'h0, vecs[i].e_instr});
    end

    // Wait states: HOLD at 0xF4, transfer, then three request cycles per word.
    wait_n = 2;
    step(1'b0, 1'b1, 1'b0, 64'h0, 32'h0);
    check("ws_xfer_valid", {63'h0, instr_valid}, 64'h1);
    check("ws_xfer_ipc", instr_pc, 64'hF4);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
      if (instr_valid) break;
      if (imem_req) n++;
    end
    check("ws_req_cycles", 64'(n), 64'd3);
    check("ws_valid", {63'h0, instr_valid}, 64'h1);
    check("ws_ipc", instr_pc, 64'hF8);
    check("ws_instr", {32'h0, instruction}, 64'hF8);
    hold_pc = instr_pc; hold_ins = instruction;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
      check("stall_valid", {63'h0, instr_valid}, 64'h1);
      check("stall_req", {63'h0, imem_req}, 64'h0);
      check("stall_ipc", instr_pc, 64'hF8);
      check("stall_instr", {32'h0, instruction}, 64'hF8);
    end
    step(1'b0, 1'b1, 1'b0, 64'h0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    check("ws_next_req", {63'h0, imem_req}, 64'h1);
    check("ws_next_addr", imem_addr, 64'hFC);
    n = 0;
    while (!instr_valid && n < 20) begin
      step(1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
      n++;
    end
    check("ws_fc_ipc", instr_pc, 64'hFC);

    // Redirect during BUSY: go to 0x20, then redirect to 0x400 in its first BUSY cycle.
    wait_n = 1;
    step(1'b0, 1'b0, 1'b1, 64'h20, 32'h0);
    step(1'b0, 1'b0, 1'b1, 64'h200, 32'h80);
    check("rb_first_addr", imem_addr, 64'h20);
    check("rb_first_req", {63'h0, imem_req}, 64'h1);
    step(1'b0, 1'b1, 1'b0, 64'h0, 32'h0);
    check("rb_new_addr", imem_addr, 64'h400);
    check("rb_old_ack", {63'h0, imem_ack}, 64'h1);
    saw_bad = 1'b0;
    n = 0;
    while (!instr_valid && n < 20) begin
      step(1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
      if (instr_valid && instr_pc == 64'h20) saw_bad = 1'b1;
      n++;
    end
    check("rb_no_stale", {63'h0, saw_bad}, 64'h0);
    check("rb_valid", {63'h0, instr_valid}, 64'h1);
    check("rb_ipc", instr_pc, 64'h400);
    check("rb_instr", {32'h0, instruction}, 64'h400);

    // Wrap: redirect to -4, fetch it, transfer, next address is 0.
    wait_n = 0;
    step(1'b0, 1'b0, 1'b1, 64'h0, 32'hFFFFFFFF);
    step(1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    check("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b0, 1'b1, 1'b0, 64'h0, 32'h0);
    check("wrap_ipc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_valid", {63'h0, instr_valid}, 64'h1);
    wait_n = 3;
    step(1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    check("wrap_next_addr", imem_addr, 64'h0);
    check("wrap_next_req", {63'h0, imem_req}, 64'h1);

    // Reset mid-request, then a stray ack during IDLE.
    step(1'b1, 1'b0, 1'b0, 64'h0, 32'h0);
    force_ack = 1'b1; force_data = 32'hDEADBEEF;
    step(1'b0, 1'b1, 1'b0, 64'h0, 32'h0);
    check("rst_req", {63'h0, imem_req}, 64'h0);
    check("rst_addr", imem_addr, 64'h0);
    check("rst_valid", {63'h0, instr_valid}, 64'h0);
    check("rst_ipc", instr_pc, 64'h0);
    check("rst_instr", {32'h0, instruction}, 64'h0);
    force_ack = 1'b0; force_data = 32'h0;
    wait_n = 0;
    step(1'b0, 1'b1, 1'b0, 64'h0, 32'h0);
    check("rst_busy_req", {63'h0, imem_req}, 64'h1);
    check("rst_busy_addr", imem_addr, 64'h0);
    check("rst_busy_valid", {63'h0, instr_valid}, 64'h0);
    step(1'b0, 1'b1, 1'b0, 64'h0, 32'h0);
    check("rst_deliver_valid", {63'h0, instr_valid}, 64'h1);
    check("rst_deliver_ipc", instr_pc, 64'h0);
    check("rst_deliver_instr", {32'h0, instruction}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
